// File: rtl/ctr_seq.sv
// ---------------------------------------------------------------------------
// ctr_seq -- measurement sequencer for the reciprocal counter.
//
// Runs one measurement per accepted start: clears the counter, requests the
// begin of counting, holds the gate open for a programmed number of clk
// cycles, requests the end, lets the counts settle and captures them. The
// captured counts are offered to the host through a valid/ready handshake.
// A per-phase timeout aborts the measurement when the counter never
// acknowledges (dead or absent input signal).
//
// Ports:
//   clk, rst      reference clock (shared with counter), sync active-high reset
//   start         measurement request, accepted only while idle
//   gate          gate time in clk cycles (0 behaves as 1), sampled on start
//   tmo           per-phase timeout in clk cycles (0 disables), sampled on start
//   crst          counter clear
//   brq, erq      begin / end requests to the counter
//   bac, eac      begin / end acknowledges from the counter
//   cta, ctc      event / reference counts from the counter
//   busy          high whenever a measurement is in progress or pending
//   vld, rdy      result handshake
//   res_a, res_c  captured event / reference counts
//   err           result is a timeout abort (qualified by vld)
// ---------------------------------------------------------------------------
module ctr_seq #(
  parameter int size = 32,
  parameter int gtw  = 32,
  parameter int tow  = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [gtw-1:0]  gate,
  input  logic [tow-1:0]  tmo,
  output logic            crst,
  output logic            brq,
  output logic            erq,
  input  logic            bac,
  input  logic            eac,
  input  logic [size-1:0] cta,
  input  logic [size-1:0] ctc,
  output logic            busy,
  output logic            vld,
  input  logic            rdy,
  output logic [size-1:0] res_a,
  output logic [size-1:0] res_c,
  output logic            err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_GATE   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [tow:0]   TMR_ONE  = {{tow{1'b0}}, 1'b1};
  localparam logic [gtw-1:0] GATE_ONE = {{(gtw-1){1'b0}}, 1'b1};

  logic [2:0]      state_q,   state_d;
  logic            phase_q,   phase_d;
  logic [tow-1:0]  tmr_q,     tmr_d;
  logic [gtw-1:0]  gateCnt_q, gateCnt_d;
  logic [gtw-1:0]  gateLen_q, gateLen_d;
  logic [tow-1:0]  tmo_q,     tmo_d;
  logic [size-1:0] resA_q,    resA_d;
  logic [size-1:0] resC_q,    resC_d;
  logic            err_q,     err_d;

  logic [tow:0]    tmrInc;
  logic [tow-1:0]  tmrSat;
  logic            tmoHit;

  // The timeout counter is evaluated one bit wider so the "reaches tmo"
  // test can never be fooled by a wrap; the stored value saturates instead.
  always_comb begin
    tmrInc = {1'b0, tmr_q} + TMR_ONE;
    tmrSat = (&tmr_q) ? tmr_q : tmrInc[tow-1:0];
    tmoHit = (tmo_q != '0) && (tmrInc >= {1'b0, tmo_q});
  end

  // Next-state logic for the whole measurement sequence. The single phase
  // bit stretches both CLR and SETTLE to exactly two cycles. Acknowledges
  // take priority over a timeout that expires on the same edge.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tmr_d     = tmr_q;
    gateCnt_d = gateCnt_q;
    gateLen_d = gateLen_q;
    tmo_d     = tmo_q;
    resA_d    = resA_q;
    resC_d    = resC_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero gate time is stored as one so GATE always lasts a cycle.
          gateLen_d = (gate == '0) ? GATE_ONE : gate;
          tmo_d     = tmo;
          phase_d   = 1'b0;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        if (phase_q) begin
          tmr_d   = '0;
          state_d = S_ARM;
        end else begin
          phase_d = 1'b1;
        end
      end
      S_ARM: begin
        if (bac) begin
          gateCnt_d = gateLen_q;
          state_d   = S_GATE;
        end else if (tmoHit) begin
          resA_d  = '0;
          resC_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmrSat;
        end
      end
      S_GATE: begin
        if (gateCnt_q <= GATE_ONE) begin
          tmr_d   = '0;
          state_d = S_STOP;
        end else begin
          gateCnt_d = gateCnt_q - GATE_ONE;
        end
      end
      S_STOP: begin
        if (eac) begin
          phase_d = 1'b0;
          state_d = S_SETTLE;
        end else if (tmoHit) begin
          resA_d  = '0;
          resC_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmrSat;
        end
      end
      S_SETTLE: begin
        if (phase_q) begin
          resA_d  = cta;
          resC_d  = ctc;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          phase_d = 1'b1;
        end
      end
      S_DONE: begin
        if (rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      tmr_q     <= '0;
      gateCnt_q <= '0;
      gateLen_q <= '0;
      tmo_q     <= '0;
      resA_q    <= '0;
      resC_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tmr_q     <= tmr_d;
      gateCnt_q <= gateCnt_d;
      gateLen_q <= gateLen_d;
      tmo_q     <= tmo_d;
      resA_q    <= resA_d;
      resC_q    <= resC_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode directly from the state register, so they are glitch-free
  // and fall to zero on the cycle after reset. brq stays high through STOP
  // and SETTLE because the counter qualifies the end with the begin state.
  always_comb begin
    crst  = (state_q == S_CLR);
    brq   = (state_q == S_ARM) || (state_q == S_GATE) ||
            (state_q == S_STOP) || (state_q == S_SETTLE);
    erq   = (state_q == S_STOP) || (state_q == S_SETTLE);
    busy  = (state_q != S_IDLE);
    vld   = (state_q == S_DONE);
    res_a = resA_q;
    res_c = resC_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_ctr_seq.sv
// ---------------------------------------------------------------------------
// tb_ctr_seq -- self-checking bench for ctr_seq.
//
// A responder plays the counter (acknowledging after a chosen delay) and the
// host (accepting the result after a chosen delay). For each measurement the
// expected phase lengths and results are computed arithmetically from the
// sequencer's rules and compared with what the bench observes on the pins.
// ---------------------------------------------------------------------------
module tb_ctr_seq;

  localparam int SIZE   = 32;
  localparam int GTW    = 32;
  localparam int TOW    = 24;
  localparam int NEVER  = 1000000;
  localparam int BUDGET = 5000;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [GTW-1:0]  gate;
  logic [TOW-1:0]  tmo;
  logic            crst;
  logic            brq;
  logic            erq;
  logic            bac;
  logic            eac;
  logic [SIZE-1:0] cta;
  logic [SIZE-1:0] ctc;
  logic            busy;
  logic            vld;
  logic            rdy;
  logic [SIZE-1:0] res_a;
  logic [SIZE-1:0] res_c;
  logic            err;

  int assertCount = 0;
  int failCount   = 0;

  ctr_seq #(.size(SIZE), .gtw(GTW), .tow(TOW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .gate  (gate),
    .tmo   (tmo),
    .crst  (crst),
    .brq   (brq),
    .erq   (erq),
    .bac   (bac),
    .eac   (eac),
    .cta   (cta),
    .ctc   (ctc),
    .busy  (busy),
    .vld   (vld),
    .rdy   (rdy),
    .res_a (res_a),
    .res_c (res_c),
    .err   (err)
  );

  // Free-running reference clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one measurement. bacDly/eacDly are the number of request cycles
  // the counter waits before acknowledging (NEVER = no acknowledge), rdyDly
  // is how long the host keeps rdy low once vld is up, startHold keeps start
  // asserted until the result is accepted.
  task automatic applyStimulus(input int gateV, input int tmoV, input int bacDly,
                               input int eacDly, input logic [SIZE-1:0] ctaV,
                               input logic [SIZE-1:0] ctcV, input int rdyDly,
                               input bit startHold);
    int gateEff, expBonly, expErq, expVld;
    logic expErr;
    logic [SIZE-1:0] expA, expC;
    int crstCnt, bOnly, erqCnt, vldCnt, brqRun, erqRun, cyc;
    bit done, holdBad, brqInVld;
    logic [SIZE-1:0] obsA, obsC;
    logic obsE;

    // Reference model: phase lengths follow from the acknowledge delays.
    gateEff = (gateV == 0) ? 1 : gateV;
    expVld  = (rdyDly == 0) ? 1 : rdyDly;
    if (tmoV != 0 && tmoV <= bacDly) begin
      expBonly = tmoV;
      expErq   = 0;
      expErr   = 1'b1;
      expA     = '0;
      expC     = '0;
    end else begin
      expBonly = bacDly + 1 + gateEff;
      if (tmoV != 0 && tmoV <= eacDly) begin
        expErq = tmoV;
        expErr = 1'b1;
        expA   = '0;
        expC   = '0;
      end else begin
        expErq = eacDly + 1 + 2;
        expErr = 1'b0;
        expA   = ctaV;
        expC   = ctcV;
      end
    end

    crstCnt = 0; bOnly = 0; erqCnt = 0; vldCnt = 0;
    brqRun = 0; erqRun = 0; cyc = 0;
    done = 0; holdBad = 0; brqInVld = 0;
    obsA = '0; obsC = '0; obsE = 1'b0;

    gate  = gateV[GTW-1:0];
    tmo   = tmoV[TOW-1:0];
    start = 1'b1;
    bac   = 1'b0;
    eac   = 1'b0;
    rdy   = (rdyDly == 0);
    cta   = ~ctaV;
    ctc   = ~ctcV;

    while (!done && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!startHold) start = 1'b0;
      if (!vld && vldCnt > 0) begin
        done = 1;
        checkOutput("busyAfterAccept", {63'd0, busy}, 64'd0);
        checkOutput("idleOutputs", {59'd0, brq, erq, crst, vld, busy}, 64'd0);
      end else begin
        if (crst) crstCnt++;
        if (brq && !erq) bOnly++;
        if (erq) erqCnt++;
        brqRun = brq ? brqRun + 1 : 0;
        erqRun = erq ? erqRun + 1 : 0;
        bac = brq && (brqRun > bacDly);
        eac = erq && (erqRun > eacDly);
        // Only the last SETTLE cycle presents the true counts.
        cta = (erq && erqRun == eacDly + 3) ? ctaV : ~ctaV;
        ctc = (erq && erqRun == eacDly + 3) ? ctcV : ~ctcV;
        if (vld) begin
          if (brq || erq) brqInVld = 1;
          if (vldCnt == 0) begin
            obsA = res_a; obsC = res_c; obsE = err;
          end else if (res_a !== obsA || res_c !== obsC || err !== obsE) begin
            holdBad = 1;
          end
          vldCnt++;
          if (vldCnt >= rdyDly) begin
            rdy   = 1'b1;
            start = 1'b0;
          end
        end
      end
    end

    if (!done) begin
      checkOutput("cycleBudget", 64'd0, 64'd1);
    end else begin
      checkOutput("crstCycles", 64'(crstCnt), 64'd2);
      checkOutput("armGateCycles", 64'(bOnly), 64'(expBonly));
      checkOutput("erqCycles", 64'(erqCnt), 64'(expErq));
      checkOutput("vldCycles", 64'(vldCnt), 64'(expVld));
      checkOutput("resA", 64'(obsA), 64'(expA));
      checkOutput("resC", 64'(obsC), 64'(expC));
      checkOutput("err", {63'd0, obsE}, {63'd0, expErr});
      checkOutput("resultHeld", {63'd0, holdBad}, 64'd0);
      checkOutput("reqLowInDone", {63'd0, brqInVld}, 64'd0);
    end

    start = 1'b0;
    bac   = 1'b0;
    eac   = 1'b0;
    rdy   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios first, then a batch of randomized measurements.
  initial begin
    int g, t, b, e, r, bOnlyCnt, cyc;
    bit h;
    logic [SIZE-1:0] ra, rc;

    rst = 1'b1; start = 1'b0; gate = '0; tmo = '0; bac = 1'b0; eac = 1'b0;
    cta = '0; ctc = '0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetCtrl", {59'd0, crst, brq, erq, busy, vld}, 64'd0);
    checkOutput("resetRes", {31'd0, err, res_a}, 64'd0);
    checkOutput("resetResC", 64'(res_c), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] nominal measurement");
    applyStimulus(100, 0, 5, 3, 32'd1000, 32'd100, 0, 0);
    $display("[TB] begin timeout");
    applyStimulus(60, 50, NEVER, 3, 32'd7, 32'd9, 0, 0);
    $display("[TB] end timeout");
    applyStimulus(30, 20, 2, NEVER, 32'd7, 32'd9, 0, 0);
    $display("[TB] delayed handshake with start held");
    applyStimulus(40, 0, 1, 2, 32'h1234_5678, 32'h0bad_cafe, 10, 1);
    $display("[TB] gate boundaries and full-scale counts");
    applyStimulus(0, 0, 0, 0, 32'hffff_ffff, 32'hffff_ffff, 1, 0);
    applyStimulus(1, 0, 0, 0, 32'h0000_0001, 32'h8000_0000, 0, 0);

    $display("[TB] reset during GATE");
    gate = 32'd100; tmo = '0; start = 1'b1; bOnlyCnt = 0; cyc = 0;
    while (bOnlyCnt < 10 && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (brq && !erq) bOnlyCnt++;
      bac = brq;
    end
    checkOutput("reachedGate", 64'(bOnlyCnt), 64'd10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midReset", {59'd0, brq, erq, vld, busy, crst}, 64'd0);
    rst = 1'b0;
    bac = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(12, 0, 3, 1, 32'd555, 32'd12, 2, 0);

    $display("[TB] randomized measurements");
    for (int i = 0; i < 20; i++) begin
      g  = int'($urandom_range(0, 150));
      t  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      b  = int'($urandom_range(0, 30));
      e  = int'($urandom_range(0, 30));
      if (t != 0 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) b = NEVER;
        else e = NEVER;
      end
      ra = $urandom;
      rc = $urandom;
      r  = int'($urandom_range(0, 5));
      h  = 1'($urandom_range(0, 1));
      applyStimulus(g, t, b, e, ra, rc, r, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
